// File: rtl/clock_div_bank.sv
// Bank of independent programmable clock dividers sharing one clock.
// Each channel produces either a one-cycle pulse or a 50% square wave. A new
// divisor written while a channel is counting waits in pend_div until the
// current period ends, so no period is ever cut short.
module clock_div_bank #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NUM_CH-1:0]                           en,
  input  logic [NUM_CH-1:0]                           mode,
  input  logic                                        div_wr,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] div_ch,
  input  logic [CNT_W-1:0]                            div_val,
  input  logic                                        restart,
  output logic [NUM_CH-1:0]                           clk_out,
  output logic [NUM_CH-1:0]                           pend
);

  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);

  logic [CNT_W-1:0]  cnt      [NUM_CH];
  logic [CNT_W-1:0]  act_div  [NUM_CH];
  logic [CNT_W-1:0]  pend_div [NUM_CH];
  logic [NUM_CH-1:0] out_q;
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] term;

  // Decode the write target and flag each channel's terminal cycle.
  // A div_ch value that matches no channel index leaves every wr_hit low,
  // which is how out-of-range writes get dropped.
  always_comb begin
    wr_hit = '0;
    term   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = div_wr && (32'(div_ch) == i);
      term[i]   = en[i] && (cnt[i] == act_div[i]);
    end
  end

  // Per-channel counter, divisor hand-over and output shaping.
  // Restart and disable both park the channel at count 0 with a low output
  // and make the newest divisor active; a write landing in that same cycle
  // goes straight to act_div.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]      <= '0;
        act_div[i]  <= DEF;
        pend_div[i] <= DEF;
      end
      out_q  <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (restart || !en[i] || term[i]) begin
          cnt[i]    <= '0;
          pend_q[i] <= 1'b0;
          if (wr_hit[i]) begin
            act_div[i]  <= div_val;
            pend_div[i] <= div_val;
          end else begin
            act_div[i]  <= pend_div[i];
          end
          if (restart || !en[i]) begin
            out_q[i] <= 1'b0;
          end else begin
            out_q[i] <= mode[i] ? ~out_q[i] : 1'b1;
          end
        end else begin
          cnt[i]   <= cnt[i] + 1'b1;
          out_q[i] <= mode[i] ? out_q[i] : 1'b0;
          if (wr_hit[i]) begin
            pend_div[i] <= div_val;
            pend_q[i]   <= 1'b1;
          end
        end
      end
    end
  end

  assign clk_out = out_q;
  assign pend    = pend_q;

endmodule

// File: tb/tb_clock_div_bank.sv
// Self-checking bench for clock_div_bank: directed scenarios with literal
// expectations, then a long randomized run checked every cycle against a
// model that tracks each channel by the absolute cycle its period began.
module tb_clock_div_bank;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam int DEF = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NCH-1:0] en;
  logic [NCH-1:0] mode;
  logic          div_wr;
  logic [1:0]    div_ch;
  logic [CW-1:0] div_val;
  logic          restart;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] pend;

  int tests = 0;
  int fails = 0;

  // Reference model state: divisors, pending flag, output level, and the
  // absolute cycle index at which each channel's current period started.
  int             cyc = 0;
  int             m_start [NCH];
  int             m_act   [NCH];
  int             m_pdiv  [NCH];
  logic [NCH-1:0] m_out;
  logic [NCH-1:0] m_pend;

  clock_div_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div_wr(div_wr),
    .div_ch(div_ch), .div_val(div_val), .restart(restart),
    .clk_out(clk_out), .pend(pend)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic logic hits(int ch);
    return div_wr && (int'(div_ch) == ch);
  endfunction

  // The divisor a channel adopts when a new period starts.
  function automatic int nextDiv(int ch);
    return hits(ch) ? int'(div_val) : m_pdiv[ch];
  endfunction

  // Behavioural model: a period ends when act+1 cycles have elapsed since
  // it began; restart or disable begins a fresh period on the next cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        m_start[ch] <= cyc;
        m_act[ch]   <= DEF;
        m_pdiv[ch]  <= DEF;
        m_out[ch]   <= 1'b0;
        m_pend[ch]  <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int ch = 0; ch < NCH; ch++) begin
        if (restart || !en[ch] || (cyc - m_start[ch] == m_act[ch])) begin
          m_start[ch] <= cyc + 1;
          m_act[ch]   <= nextDiv(ch);
          m_pdiv[ch]  <= nextDiv(ch);
          m_pend[ch]  <= 1'b0;
          if (restart || !en[ch]) m_out[ch] <= 1'b0;
          else                    m_out[ch] <= mode[ch] ? ~m_out[ch] : 1'b1;
        end else begin
          if (!mode[ch]) m_out[ch] <= 1'b0;
          if (hits(ch)) begin
            m_pdiv[ch] <= int'(div_val);
            m_pend[ch] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare the DUT against the model; called once per sampled cycle.
  task automatic checkOutput();
    check("model_clk_out", 32'(clk_out), 32'(m_out));
    check("model_pend", 32'(pend), 32'(m_pend));
  endtask

  // Drive one cycle's inputs just after the falling edge, then sample at the
  // next falling edge.
  task automatic applyStimulus(input logic [NCH-1:0] e, input logic [NCH-1:0] m,
                               input logic w, input logic [1:0] c,
                               input logic [CW-1:0] v, input logic r);
    #1;
    en = e; mode = m; div_wr = w; div_ch = c; div_val = v; restart = r;
    @(negedge clk);
    checkOutput();
  endtask

  // Pulse rst_n low between clock edges and check outputs clear at once.
  task automatic asyncReset();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_clk_out", 32'(clk_out), 32'd0);
    check("async_rst_pend", 32'(pend), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput();
  endtask

  logic [2:0] rs_exp [8];

  initial begin
    rst_n = 1'b0; en = 4'b0101; mode = '0; div_wr = 1'b0;
    div_ch = '0; div_val = '0; restart = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_clk_out", 32'(clk_out), 32'd0);
    check("reset_pend", 32'(pend), 32'd0);
    rst_n = 1'b1;

    // Default divisor pulses on ch0, a write landing on ch2's terminal cycle,
    // and a deferred write on ch0 that must not disturb its current period.
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(4'b0101, 4'b0000, (k == 3) || (k == 5), (k == 5) ? 2'd2 : 2'd0,
                    (k == 5) ? 16'd0 : 16'd4, 1'b0);
      check("pulse_ch0", 32'(clk_out[0]), 32'((k == 5) || (k == 10)));
      check("div0_ch2", 32'(clk_out[2]), 32'(k >= 5));
      check("pend_ch0", 32'(pend[0]), 32'((k == 3) || (k == 4)));
      check("pend_ch2", 32'(pend[2]), 32'd0);
    end

    // A pending divisor must be discarded by an asynchronous reset.
    applyStimulus(4'b0101, 4'b0000, 1'b1, 2'd0, 16'd7, 1'b0);
    check("pend_before_rst", 32'(pend[0]), 32'd1);
    asyncReset();
    for (int k = 2; k <= 5; k++) begin
      applyStimulus(4'b0101, 4'b0000, 1'b0, 2'd0, 16'd0, 1'b0);
      check("post_rst_ch0", 32'(clk_out[0]), 32'(k == 5));
    end

    // Divisors 2, 3, 6 loaded while idle, then a restart aligns them.
    applyStimulus(4'b0000, 4'b0000, 1'b1, 2'd0, 16'd2, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 2'd1, 16'd3, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 2'd2, 16'd6, 1'b0);
    check("idle_pend", 32'(pend), 32'd0);
    rs_exp = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b000, 3'b001, 3'b100};
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b0111, 4'b0000, 1'b0, 2'd0, 16'd0, k == 0);
      check("restart_align", 32'(clk_out[2:0]), 32'(rs_exp[k]));
    end

    // Randomized traffic; enables and modes change only occasionally so that
    // full periods, square waves and re-enables all get exercised.
    for (int k = 0; k < 3000; k++) begin
      logic [NCH-1:0] e;
      logic [NCH-1:0] m;
      e = en;
      m = mode;
      if ($urandom_range(0, 15) == 0) e[$urandom_range(0, NCH - 1)] ^= 1'b1;
      if ($urandom_range(0, 31) == 0) m[$urandom_range(0, NCH - 1)] ^= 1'b1;
      if ($urandom_range(0, 699) == 0) begin
        asyncReset();
      end else begin
        applyStimulus(e, m, $urandom_range(0, 5) == 0, 2'($urandom_range(0, NCH - 1)),
                      16'($urandom_range(0, 6)), $urandom_range(0, 59) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_div_bank.md
CLOCK_DIV_BANK -- requirements
Module: clock_div_bank

Interface
- REQ-001: Parameter NUM_CH, default 4: number of independent divider channels, range 1..16.
- REQ-002: Parameter CNT_W, default 16: width of each channel's counter and divisor.
- REQ-003: Parameter DEF_DIV, default 4: active and pending divisor of every channel after reset.
- REQ-004: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: en  input  NUM_CH  per-channel enable.
- REQ-007: mode  input  NUM_CH  per-channel output mode; 0 = pulse, 1 = square.
- REQ-008: div_wr  input  1  divisor write strobe, valid for one cycle.
- REQ-009: div_ch  input  clog2(NUM_CH), minimum 1  target channel of the write.
- REQ-010: div_val  input  CNT_W  divisor D; channel period is D+1 clk cycles.
- REQ-011: restart  input  1  synchronous phase-align of all channels.
- REQ-012: clk_out  output  NUM_CH  per-channel divided output, registered.
- REQ-013: pend  output  NUM_CH  per-channel flag: a written divisor is not yet active.

Function
- REQ-014: Each channel SHALL hold cnt, active divisor act_div, pending divisor pend_div, and pend flag.
- REQ-015: With en=1, cnt SHALL go from act_div to 0 (terminal cycle); otherwise it increments by 1.
- REQ-016: Pulse mode SHALL set clk_out=1 in the cycle after the terminal cycle and 0 otherwise: one-cycle pulse, period act_div+1.
- REQ-017: Square mode SHALL toggle clk_out in the cycle after each terminal cycle: period 2*(act_div+1), 50% duty.
- REQ-018: act_div=0 SHALL give clk_out constantly 1 in pulse mode and a toggle every cycle in square mode.
- REQ-019: div_wr with div_ch < NUM_CH SHALL load div_val into pend_div of that channel and set pend.
- REQ-019a: div_wr with div_ch >= NUM_CH SHALL be ignored.
- REQ-020: pend_div SHALL transfer to act_div, and pend SHALL clear, only on a terminal cycle, while en=0, or on restart, so no period is truncated.
- REQ-021: div_wr in the same cycle as a terminal cycle of the target channel SHALL take effect immediately; the next period uses div_val.
- REQ-021a: In that case pend SHALL remain 0.
- REQ-022: A second div_wr before transfer SHALL overwrite pend_div; only the last value applies.
- REQ-023: en=0 SHALL force cnt=0 and clk_out=0 on the next edge.
- REQ-023a: Re-enable SHALL start counting from 0, so the first output occurs act_div+1 cycles after re-enable.
- REQ-024: A change of mode SHALL take effect on the next edge.
- REQ-024a: Entering pulse mode with clk_out=1 SHALL drive clk_out to 0 unless that edge follows a terminal cycle.
- REQ-025: restart=1 SHALL set every channel's cnt=0 and clk_out=0 and apply any pending divisors in the same edge.
- REQ-025a: restart SHALL take priority over count and over en.
- REQ-025b: div_wr coincident with restart SHALL be applied directly to act_div.
- REQ-026: Counters SHALL be unsigned CNT_W bits; since cnt never exceeds act_div, no overflow path exists.

Reset
- REQ-027: rst_n=0 SHALL asynchronously set all cnt=0, clk_out=0, and pend=0.
- REQ-027a: rst_n=0 SHALL asynchronously set act_div=DEF_DIV and pend_div=DEF_DIV on all channels.
- REQ-028: Reset asserted mid-period SHALL discard any partial period and any pending divisor.
- REQ-028a: Counting SHALL resume on the first rising edge after rst_n deasserts, when en=1.

Verification
- REQ-029: Reset, en=4'b0001, mode=0, DEF_DIV=4 -> clk_out[0] single-cycle pulse every 5 cycles; other channels 0; pend=0.
- REQ-030: ch1 mode=1, div_wr div_val=2 while cnt=1 of DEF_DIV=4 -> pend[1]=1 until terminal, current period completes at 5 cycles, then clk_out[1] toggles every 3 cycles.
- REQ-031: div_wr div_val=0 on ch2 coincident with its terminal cycle -> pend[2] stays 0; pulse mode clk_out[2]=1 every cycle thereafter.
- REQ-032: Channels with divisors 2, 3, 6 running, then restart pulse -> all clk_out=0 next cycle; first pulses at 3, 4, 7 cycles after restart.
- REQ-033: rst_n asserted asynchronously between clock edges mid-period with pend set -> outputs 0 immediately, pend=0, act_div=4 after release.
- REQ-034: en[3] dropped for 10 cycles then raised, square mode, div 4 -> clk_out[3]=0 while disabled; first toggle 5 cycles after re-enable.
